token_receiver: RTL and testbench

- Result sink directly downstream of the CUES data-driven processor output port: the swirl output token bundle and its send/ack pair.
- Acknowledges each output token using 2-phase (transition) signalling and buffers it in a FIFO for readout.
- Counts accepted tokens against an expected number, and accumulates a checksum over operand fields.
- Raises done/overrun status for the board LEDs and debug header, closing the DataSender → CUES → receiver loop.

---
 rtl/token_receiver.sv | 168 ++++++++++++++++
 tb/tb_token_receiver.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/token_receiver.sv
// Result sink for the CUES output port: 2-phase acks each token, buffers it, counts and checksums per run.
// Latency: send transition -> ack toggle and FIFO/count/checksum update at the third clk edge; FIFO read is show-ahead.
// Backpressure: when the FIFO is full the pending token is left unacknowledged until space frees up.
module token_receiver #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i_tr,
    input  logic [CNT_W-1:0] expected_num_i_tr,
    input  logic             send_i_tr,
    input  logic [61:0]      token_i_tr,
    output logic             ack_o_tr,
    input  logic             rd_en_i_tr,
    output logic [61:0]      rd_data_o_tr,
    output logic             empty_o_tr,
    output logic             full_o_tr,
    output logic [CNT_W-1:0] recv_count_o_tr,
    output logic [31:0]      checksum_o_tr,
    output logic             done_o_tr,
    output logic             overrun_o_tr
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic        lr;
        logic        uni_opr;
        logic [1:0]  mem_wen;
        logic [13:0] node;
        logic [11:0] gen;
        logic [31:0] opr;
    } token_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    token_t           tok;
    token_t           mem_q [DEPTH];

    logic             send_s1_q;
    logic             send_s2_q;
    logic             ack_q;
    logic             ack_d;
    logic             start_q;
    state_t           state_q;
    state_t           state_d;
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      wr_ptr_d;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      rd_ptr_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [31:0]      sum_q;
    logic [31:0]      sum_d;
    logic             done_q;
    logic             done_d;
    logic             ovr_q;
    logic             ovr_d;

    logic             start_edge;
    logic             pending;
    logic             empty;
    logic             full;
    logic             accept;
    logic             pop;

    assign tok        = token_t'(token_i_tr);
    assign start_edge = start_i_tr & ~start_q;
    assign pending    = send_s2_q ^ ack_q;
    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // Full is judged on the registered pointers, so a same-cycle pop cannot make room for a push.
    assign accept     = pending && ((state_q == ST_RUN) || (state_q == ST_DONE)) &&
                        !full && !start_edge;
    assign pop        = rd_en_i_tr && !empty && !start_edge;
    assign cnt_inc    = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    assign ack_d      = ack_q ^ accept;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        done_d   = done_q;
        ovr_d    = ovr_q;
        if (start_edge) begin
            // A new run discards buffered results but keeps the handshake phase intact.
            state_d  = ST_RUN;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            sum_d    = '0;
            done_d   = 1'b0;
            ovr_d    = 1'b0;
        end else begin
            if (accept) begin
                wr_ptr_d = wr_ptr_q + (AW+1)'(1);
                cnt_d    = cnt_inc;
                sum_d    = sum_q + tok.opr;
                case (state_q)
                    ST_RUN: begin
                        if ((expected_num_i_tr != '0) && (cnt_inc == expected_num_i_tr)) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end
                    ST_DONE: ovr_d = 1'b1;
                    default: ;
                endcase
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            send_s1_q <= 1'b0;
            send_s2_q <= 1'b0;
            ack_q     <= 1'b0;
            start_q   <= 1'b0;
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            sum_q     <= '0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            send_s1_q <= send_i_tr;
            send_s2_q <= send_s1_q;
            ack_q     <= ack_d;
            start_q   <= start_i_tr;
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            done_q    <= done_d;
            ovr_q     <= ovr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q[AW-1:0]] <= tok;
        end
    end

    assign ack_o_tr        = ack_q;
    assign rd_data_o_tr    = empty ? 62'd0 : 62'(mem_q[rd_ptr_q[AW-1:0]]);
    assign empty_o_tr      = empty;
    assign full_o_tr       = full;
    assign recv_count_o_tr = cnt_q;
    assign checksum_o_tr   = sum_q;
    assign done_o_tr       = done_q;
    assign overrun_o_tr    = ovr_q;

endmodule

// File: tb/tb_token_receiver.sv
// Scoreboard bench for token_receiver: tokens queued at send time, compared at FIFO readout.
module tb_token_receiver;

    localparam int DEPTH = 16;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start_i = 1'b0;
    logic [CNT_W-1:0] expected_num = '0;
    logic             send = 1'b0;
    logic [61:0]      token = '0;
    logic             ack;
    logic             rd_en = 1'b0;
    logic [61:0]      rd_data;
    logic             empty;
    logic             full;
    logic [CNT_W-1:0] recv_count;
    logic [31:0]      checksum;
    logic             done;
    logic             overrun;

    logic [61:0]      sb [$];
    logic [31:0]      exp_sum;
    int               n_vec = 0;
    int               n_err = 0;

    token_receiver #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .start_i_tr        (start_i),
        .expected_num_i_tr (expected_num),
        .send_i_tr         (send),
        .token_i_tr        (token),
        .ack_o_tr          (ack),
        .rd_en_i_tr        (rd_en),
        .rd_data_o_tr      (rd_data),
        .empty_o_tr        (empty),
        .full_o_tr         (full),
        .recv_count_o_tr   (recv_count),
        .checksum_o_tr     (checksum),
        .done_o_tr         (done),
        .overrun_o_tr      (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All tasks begin and end just after a negedge.
    task automatic start_run(input logic [CNT_W-1:0] exp_n);
        expected_num = exp_n;
        start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        exp_sum = 32'd0;
    endtask

    task automatic send_tok(input logic [31:0] opr);
        logic [61:0] t;
        t = {30'($urandom()), opr};
        token = t;
        send = ~send;
        sb.push_back(t);
        exp_sum = exp_sum + opr;
    endtask

    task automatic wait_ack(input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (ack === send) break;
        end
        n_vec++;
        if (ack !== send) begin
            n_err++;
            $display("FAIL %s: ack=%b send=%b after %0d cycles", name, ack, send, budget);
        end
    endtask

    task automatic pop_check(input string name);
        logic [61:0] e;
        n_vec++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL %s: scoreboard empty, rd_data=%h", name, rd_data);
        end else begin
            e = sb.pop_front();
            if (empty !== 1'b0 || rd_data !== e) begin
                n_err++;
                $display("FAIL %s: rd_data=%h empty=%b, want %h empty=0", name, rd_data, empty, e);
            end
        end
        rd_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic drain(input string name);
        while (sb.size() > 0) pop_check(name);
        n_vec++;
        if (empty !== 1'b1) begin
            n_err++;
            $display("FAIL %s_empty: empty=%b want 1", name, empty);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({ack, empty, full, rd_data, recv_count, checksum, done, overrun} !==
            {1'b0, 1'b1, 1'b0, 62'd0, {CNT_W{1'b0}}, 32'd0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset: ack=%b empty=%b full=%b rd=%h cnt=%0d sum=%0d done=%b ovr=%b",
                     ack, empty, full, rd_data, recv_count, checksum, done, overrun);
        end
        rst = 1'b0;
        // No acks while idle.
        send_tok(32'd99);
        repeat (6) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (ack !== 1'b0) begin
            n_err++;
            $display("FAIL idle_no_ack: ack=%b want 0", ack);
        end
        sb.delete();
    endtask

    task automatic test_basic();
        start_run(8'd3);
        // idle leftover token is accepted once RUN begins
        wait_ack(4, "idle_pending_ack");
        sb.delete();
        start_run(8'd3);
        for (int k = 1; k <= 3; k++) begin
            send_tok(32'(k));
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
            n_vec++;
            if (ack === send) begin
                n_err++;
                $display("FAIL basic_early_ack%0d: ack=%b toggled before third edge", k, ack);
            end
            @(posedge clk);
            @(negedge clk);
            n_vec++;
            if (ack !== send || recv_count !== CNT_W'(k)) begin
                n_err++;
                $display("FAIL basic_ack%0d: ack=%b cnt=%0d, want ack=%b cnt=%0d", k, ack, recv_count, send, k);
            end
        end
        n_vec++;
        if (checksum !== 32'd6 || done !== 1'b1 || overrun !== 1'b0) begin
            n_err++;
            $display("FAIL basic_status: sum=%0d done=%b ovr=%b, want 6 1 0", checksum, done, overrun);
        end
        drain("basic_rd");
    endtask

    task automatic test_backpressure();
        start_run(8'd0);
        for (int k = 1; k <= DEPTH; k++) begin
            send_tok(32'(k * 7));
            wait_ack(5, "bp_ack");
        end
        send_tok(32'd1000);
        repeat (6) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (full !== 1'b1 || ack === send || recv_count !== CNT_W'(DEPTH)) begin
            n_err++;
            $display("FAIL bp_hold: full=%b ack=%b send=%b cnt=%0d, want full=1 ack!=send cnt=%0d",
                     full, ack, send, recv_count, DEPTH);
        end
        pop_check("bp_first_rd");
        wait_ack(2, "bp_release_ack");
        n_vec++;
        if (full !== 1'b1 || checksum !== exp_sum || recv_count !== CNT_W'(DEPTH + 1)) begin
            n_err++;
            $display("FAIL bp_after: full=%b sum=%0d cnt=%0d, want full=1 sum=%0d cnt=%0d",
                     full, checksum, recv_count, exp_sum, DEPTH + 1);
        end
        drain("bp_rd");
    endtask

    task automatic test_overrun();
        start_run(8'd2);
        send_tok(32'd10);
        wait_ack(5, "ovr_ack1");
        send_tok(32'd20);
        wait_ack(5, "ovr_ack2");
        n_vec++;
        if (done !== 1'b1 || overrun !== 1'b0) begin
            n_err++;
            $display("FAIL ovr_done: done=%b ovr=%b, want 1 0", done, overrun);
        end
        send_tok(32'd30);
        wait_ack(5, "ovr_ack3");
        n_vec++;
        if (done !== 1'b1 || overrun !== 1'b1 || recv_count !== CNT_W'(3) || checksum !== 32'd60) begin
            n_err++;
            $display("FAIL ovr_set: done=%b ovr=%b cnt=%0d sum=%0d, want 1 1 3 60",
                     done, overrun, recv_count, checksum);
        end
        drain("ovr_rd");
    endtask

    task automatic test_start_pending();
        logic [61:0] t;
        start_run(8'd0);
        for (int k = 0; k < 5; k++) begin
            send_tok(32'(k + 40));
            wait_ack(5, "sp_fill_ack");
        end
        send_tok(32'd77);
        t = token;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        n_vec++;
        if (empty !== 1'b1 || recv_count !== '0 || checksum !== 32'd0 || ack === send) begin
            n_err++;
            $display("FAIL sp_clear: empty=%b cnt=%0d sum=%0d ack=%b send=%b, want 1 0 0 ack!=send",
                     empty, recv_count, checksum, ack, send);
        end
        wait_ack(2, "sp_late_ack");
        n_vec++;
        if (recv_count !== CNT_W'(1) || checksum !== 32'd77) begin
            n_err++;
            $display("FAIL sp_count: cnt=%0d sum=%0d, want 1 77", recv_count, checksum);
        end
        sb.delete();
        sb.push_back(t);
        drain("sp_rd");
    endtask

    task automatic test_back_to_back();
        start_run(8'd0);
        for (int k = 0; k < 4; k++) begin
            send_tok(32'(k + 100));
            wait_ack(5, "b2b_fill_ack");
        end
        send_tok(32'd200);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        pop_check("b2b_simul_rd");
        n_vec++;
        if (ack !== send || empty !== 1'b0 || rd_data !== sb[0]) begin
            n_err++;
            $display("FAIL b2b_simul: ack=%b send=%b empty=%b rd=%h, want ack=send empty=0 rd=%h",
                     ack, send, empty, rd_data, sb[0]);
        end
        n_vec++;
        if (sb.size() != 4) begin
            n_err++;
            $display("FAIL b2b_occ: scoreboard holds %0d, want 4", sb.size());
        end
        drain("b2b_rd");
        rd_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rd_en = 1'b0;
        n_vec++;
        if (rd_data !== 62'd0 || empty !== 1'b1 || full !== 1'b0 || recv_count !== CNT_W'(5)) begin
            n_err++;
            $display("FAIL b2b_empty_rd: rd=%h empty=%b full=%b cnt=%0d, want 0 1 0 5",
                     rd_data, empty, full, recv_count);
        end
    endtask

    task automatic test_rst_mid();
        start_run(8'd0);
        send_tok(32'd5);
        wait_ack(5, "rst_pre_ack");
        if (ack !== 1'b1) begin
            send_tok(32'd6);
            wait_ack(5, "rst_pre_ack2");
        end
        send_tok(32'd7);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        send = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({ack, empty, full, rd_data, recv_count, checksum, done, overrun} !==
            {1'b0, 1'b1, 1'b0, 62'd0, {CNT_W{1'b0}}, 32'd0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL rst_mid: ack=%b empty=%b full=%b rd=%h cnt=%0d sum=%0d done=%b ovr=%b",
                     ack, empty, full, rd_data, recv_count, checksum, done, overrun);
        end
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        start_run(8'd1);
        send_tok(32'd11);
        wait_ack(5, "rst_post_ack");
        n_vec++;
        if (recv_count !== CNT_W'(1) || done !== 1'b1 || checksum !== 32'd11) begin
            n_err++;
            $display("FAIL rst_post: cnt=%0d done=%b sum=%0d, want 1 1 11", recv_count, done, checksum);
        end
        drain("rst_rd");
    endtask

    initial begin
        exp_sum = 32'd0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_backpressure();
        test_overrun();
        test_start_pending();
        test_back_to_back();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
